// File: rtl/rmii_tx_pkg.sv
// -----------------------------------------------------------------------------
// rmii_tx_pkg
// Shared definitions for the RMII transmit framer and the CRC-32 dibit engine.
//   state_t            : framer FSM states (PAD is used only when the
//                        RMII_TX_PAD_EN macro is defined)
//   CRC32_POLY_REFL    : reflected CRC-32 polynomial
//   CRC32_INIT         : CRC register start value
//   PRE_DIBIT          : preamble dibit (0x55 byte, LSB-first)
//   SFD_DIBITS         : SFD dibit sequence, element 0 in bits [1:0]
//   *_DEF              : default parameter values for the framer
// -----------------------------------------------------------------------------
package rmii_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam logic [1:0] PRE_DIBIT  = 2'b01;
  // Wire order 01,01,01,11 (0xD5 sent LSB-first).
  localparam logic [7:0] SFD_DIBITS = 8'b11_01_01_01;

  localparam int PREAMBLE_DIBITS_DEF = 28;
  localparam int IFG_DIBITS_DEF      = 48;
  localparam int MIN_BYTES_DEF       = 60;

endpackage

// File: rtl/rmii_tx_framer_if.sv
// -----------------------------------------------------------------------------
// rmii_tx_framer_if
// Dibit stream from the packet-buffer transmit interface into the framer.
//   tx_axi_valid : upstream dibit valid, held high for the whole frame
//   tx_axi_ready : framer accepts the current dibit this cycle
//   tx_axi_data  : payload dibit, LSB-first within each byte
// Modports: master = upstream source, slave = framer.
// -----------------------------------------------------------------------------
interface rmii_tx_framer_if;
  logic       tx_axi_valid;
  logic       tx_axi_ready;
  logic [1:0] tx_axi_data;

  modport master (output tx_axi_valid, output tx_axi_data, input  tx_axi_ready);
  modport slave  (input  tx_axi_valid, input  tx_axi_data, output tx_axi_ready);
endinterface

// File: rtl/crc32_dibit.sv
// -----------------------------------------------------------------------------
// crc32_dibit
// Combinational next-state of a reflected CRC-32 advanced by two bits.
// Shared by the transmit framer and the receive checker.
//   i_crc  : current CRC register
//   i_data : input dibit, bit 0 is first on the wire
//   o_crc  : CRC register after both bits
// -----------------------------------------------------------------------------
module crc32_dibit
  import rmii_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [1:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_mid;

  always_comb begin
    w_mid = {1'b0, i_crc[31:1]} ^ ((i_crc[0] ^ i_data[0]) ? CRC32_POLY_REFL : 32'h0);
    o_crc = {1'b0, w_mid[31:1]} ^ ((w_mid[0] ^ i_data[1]) ? CRC32_POLY_REFL : 32'h0);
  end

endmodule

// File: rtl/rmii_tx_framer.sv
// -----------------------------------------------------------------------------
// rmii_tx_framer
// Wraps each upstream frame in preamble + SFD, appends the CRC-32 FCS and
// enforces the inter-frame gap, driving the RMII TXEN/TXD pins.
//   clk    : 50 MHz RMII reference clock
//   rst    : asynchronous active-low reset
//   tx_axi : dibit stream in (slave modport of rmii_tx_framer_if)
//   txen   : RMII transmit enable
//   txd    : RMII transmit dibit
//   busy   : high in any state other than IDLE
//   tx_err : one-cycle pulse, frame ended on a non-byte boundary
// Optional feature macro: RMII_TX_PAD_EN -- pads aligned short frames with
// 00 dibits up to MIN_BYTES before the FCS.
// All outputs are registered; txd/txen lag the accepting cycle by one clk.
// -----------------------------------------------------------------------------
module rmii_tx_framer
  import rmii_tx_pkg::*;
#(
  parameter int PREAMBLE_DIBITS = PREAMBLE_DIBITS_DEF,
  parameter int IFG_DIBITS      = IFG_DIBITS_DEF
`ifdef RMII_TX_PAD_EN
  , parameter int MIN_BYTES     = MIN_BYTES_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  rmii_tx_framer_if.slave        tx_axi,
  output logic                   txen,
  output logic [1:0]             txd,
  output logic                   busy,
  output logic                   tx_err
);

  localparam logic [7:0] PRE_LEN  = 8'(PREAMBLE_DIBITS);
  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_DIBITS + 3);
  localparam logic [7:0] FCS_LAST = 8'd15;
  localparam logic [7:0] IFG_LAST = 8'(IFG_DIBITS);
`ifdef RMII_TX_PAD_EN
  localparam logic [15:0] MIN_DIBITS = 16'(MIN_BYTES * 4);
`endif

  state_t      r_state, w_nxt_state;
  logic [7:0]  r_cnt,   w_nxt_cnt;     // preamble / FCS / IFG position
  logic [31:0] r_crc,   w_nxt_crc;
  logic [15:0] r_dcnt,  w_nxt_dcnt;    // payload (+pad) dibits, saturating
  logic        r_txen,  w_nxt_txen;
  logic [1:0]  r_txd,   w_nxt_txd;
  logic        r_ready, w_nxt_ready;
  logic        r_err,   w_nxt_err;
  logic        r_busy;

  logic [1:0]  w_crc_in;
  logic [31:0] w_crc_next;
  logic [1:0]  w_sfd_idx;
  logic [1:0]  w_pre_dibit;
  logic [15:0] w_dcnt_inc;
  logic        w_go_fcs;

  // Pad dibits are zeros, so the CRC input is forced to 00 outside accepted data.
  assign w_crc_in = (r_state == DATA && tx_axi.tx_axi_valid) ? tx_axi.tx_axi_data : 2'b00;

  crc32_dibit u_crc (
    .i_crc  (r_crc),
    .i_data (w_crc_in),
    .o_crc  (w_crc_next)
  );

  assign w_sfd_idx   = r_cnt[1:0] - 2'(PREAMBLE_DIBITS);
  assign w_pre_dibit = (r_cnt < PRE_LEN) ? PRE_DIBIT : SFD_DIBITS[{w_sfd_idx, 1'b0} +: 2];
  assign w_dcnt_inc  = (&r_dcnt) ? r_dcnt : r_dcnt + 16'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_crc   = r_crc;
    w_nxt_dcnt  = r_dcnt;
    w_nxt_txen  = 1'b0;
    w_nxt_txd   = 2'b00;
    w_nxt_ready = 1'b0;
    w_nxt_err   = 1'b0;
    w_go_fcs    = 1'b0;

    case (r_state)
      IDLE: begin
        // The IDLE edge already emits preamble dibit 0 so txen rises 1 clk after valid.
        if (tx_axi.tx_axi_valid) begin
          w_nxt_state = PRE;
          w_nxt_txen  = 1'b1;
          w_nxt_txd   = PRE_DIBIT;
          w_nxt_cnt   = 8'd1;
          w_nxt_crc   = CRC32_INIT;
          w_nxt_dcnt  = '0;
        end
      end

      PRE: begin
        w_nxt_txen = 1'b1;
        w_nxt_txd  = w_pre_dibit;
        w_nxt_cnt  = r_cnt + 8'd1;
        // Raise ready with the last SFD dibit so the first payload dibit follows it directly.
        if (r_cnt == PRE_LAST) begin
          w_nxt_state = DATA;
          w_nxt_ready = 1'b1;
          w_nxt_cnt   = '0;
        end
      end

      DATA: begin
        if (tx_axi.tx_axi_valid) begin
          w_nxt_ready = 1'b1;
          w_nxt_txen  = 1'b1;
          w_nxt_txd   = tx_axi.tx_axi_data;
          w_nxt_crc   = w_crc_next;
          w_nxt_dcnt  = w_dcnt_inc;
        end else begin
          w_nxt_err = |r_dcnt[1:0];
`ifdef RMII_TX_PAD_EN
          if (r_dcnt[1:0] == 2'b00 && r_dcnt < MIN_DIBITS) begin
            w_nxt_state = PAD;
            w_nxt_txen  = 1'b1;
            w_nxt_crc   = w_crc_next;
            w_nxt_dcnt  = w_dcnt_inc;
          end else begin
            w_go_fcs = 1'b1;
          end
`else
          w_go_fcs = 1'b1;
`endif
        end
      end

`ifdef RMII_TX_PAD_EN
      PAD: begin
        w_nxt_txen = 1'b1;
        if (r_dcnt == MIN_DIBITS) begin
          w_go_fcs = 1'b1;
        end else begin
          w_nxt_crc  = w_crc_next;
          w_nxt_dcnt = w_dcnt_inc;
        end
      end
`endif

      FCS: begin
        w_nxt_txen = 1'b1;
        w_nxt_txd  = ~r_crc[1:0];
        w_nxt_crc  = {2'b00, r_crc[31:2]};
        w_nxt_cnt  = r_cnt + 8'd1;
        if (r_cnt == FCS_LAST) begin
          w_nxt_state = IFG;
          w_nxt_cnt   = '0;
        end
      end

      IFG: begin
        // The first IFG cycle still shows the last FCS dibit (output lag),
        // hence IFG_DIBITS+1 cycles in this state for IFG_DIBITS low cycles.
        w_nxt_cnt = r_cnt + 8'd1;
        if (r_cnt == IFG_LAST) begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = '0;
        end
      end

      default: w_nxt_state = IDLE;
    endcase

    // FCS dibit 0 goes out on the same edge that ends data/pad; the CRC
    // register then shifts right so bits [1:0] always hold the next FCS dibit.
    if (w_go_fcs) begin
      w_nxt_state = FCS;
      w_nxt_txen  = 1'b1;
      w_nxt_txd   = ~r_crc[1:0];
      w_nxt_crc   = {2'b00, r_crc[31:2]};
      w_nxt_cnt   = 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_crc   <= CRC32_INIT;
      r_dcnt  <= '0;
      r_txen  <= 1'b0;
      r_txd   <= 2'b00;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_crc   <= w_nxt_crc;
      r_dcnt  <= w_nxt_dcnt;
      r_txen  <= w_nxt_txen;
      r_txd   <= w_nxt_txd;
      r_ready <= w_nxt_ready;
      r_err   <= w_nxt_err;
      r_busy  <= (w_nxt_state != IDLE);
    end
  end

  assign tx_axi.tx_axi_ready = r_ready;
  assign txen   = r_txen;
  assign txd    = r_txd;
  assign busy   = r_busy;
  assign tx_err = r_err;

endmodule
